alu_operand_loader: RTL and testbench
=====================================

Name: alu_operand_loader

Overview:
- Upstream issue stage for the 4-bit ALU in the tt_um_example top.
- Captures operand A, then operand B plus a 3-bit opcode, from the 8-bit `ui_in` pin bus using a pin-driven load strobe.
- Presents the complete operation to the ALU over a valid/ready handshake.
- Adds a strobe synchroniser, an inter-operand timeout and sticky error flags.

Parameters:
- DATA_W, 4, operand width; equals the ALU operand width.
- OP_W, 3, opcode width.
- SYNC_STAGES, 2, flops in the strobe synchroniser; minimum 2.
- TIMEOUT, 255, enabled cycles allowed in GOT_A before abort; minimum 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; FSM and timeout counter frozen while low.
- ui_in  in  8  [3:0] data nibble, [6:4] opcode, [7] load strobe (asynchronous pin).
- op_a  out  DATA_W  operand A to ALU.
- op_b  out  DATA_W  operand B to ALU.
- op_code  out  OP_W  opcode to ALU.
- op_valid  out  1  operation valid.
- op_ready  in  1  ALU accepts operation.
- busy  out  1  high in GOT_A or ISSUE.
- timeout_err  out  1  sticky: GOT_A timed out.
- overrun_err  out  1  sticky: strobe edge seen during ISSUE.

Behaviour:
- Reset is asynchronous. While rst_n=0, all outputs are 0, state is IDLE, and the sync chain, edge history and counter are all 0. Assertion mid-operation aborts immediately; no partial operation survives.
- ui_in[7] passes through SYNC_STAGES flops plus one history flop.
- A strobe event is synced-high AND history-low, evaluated only when ena=1. Events while ena=0 are discarded, not queued.
- Latency: a pin rise meeting setup before edge k produces its capture at edge k+SYNC_STAGES, which is edge k+2 at the default.
- ui_in[6:0] is sampled directly at the capture edge. The driver holds ui_in[6:0] stable from strobe rise until strobe fall.
- IDLE: on a strobe event, op_a <= ui_in[3:0], both error flags clear, counter clears, go to GOT_A.
- GOT_A: on a strobe event, op_b <= ui_in[3:0] and op_code <= ui_in[6:4], go to ISSUE.
- GOT_A, no event: the counter increments each enabled cycle. When the counter reaches TIMEOUT-1 without an event, go to IDLE, set timeout_err, and leave op_a unchanged. An event in that same cycle wins.
- ISSUE: op_valid=1 from the cycle after B capture. op_a, op_b and op_code are held stable while op_valid=1.
- Transfer occurs on any edge with op_valid & op_ready. The next cycle has op_valid=0 and state IDLE.
- op_ready already high on the first op_valid cycle transfers in that cycle.
- A strobe event during ISSUE sets overrun_err and is otherwise ignored. This includes the transfer cycle.
- ena=0 during ISSUE holds op_valid high and the data stable. A transfer still completes if op_ready=1, because the handshake is not gated by ena.
- op_a, op_b and op_code keep their last values in IDLE; they are not zeroed after transfer.
- busy = (state != IDLE), registered from state.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

Decomposition:
- Package alu_pkg holds:
  - the opcode enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, SHR=7;
  - the loader state enum: IDLE, GOT_A, ISSUE;
  - DATA_W/OP_W defaults and the ui_in bit-field index constants.
- One sub-module, sync_edge_det (parameter SYNC_STAGES; ports clk, rst_n, async_in, en, rise_pulse), is shared with later pin-input blocks.

Test Plan:
- Reset mid-ISSUE:
  - Stimulus: rst_n low for 1 cycle while op_valid=1.
  - Required: op_valid, busy and flags are 0 immediately (asynchronous), state IDLE; the next strobe is captured as operand A.
- Basic load:
  - Stimulus: strobe with ui_in=0x8A (A=0xA), then strobe with ui_in=0x93 (B=0x3, op=1 SUB), op_ready tied high.
  - Required: op_a=0xA, op_b=0x3, op_code=1 with op_valid high for exactly 1 cycle, starting 1 cycle after the second capture edge.
- Backpressure:
  - Stimulus: the same load with op_ready=0 for 5 cycles, then 1.
  - Required: op_valid high for 6 cycles with stable data; idle the cycle after the transfer.
- Timeout:
  - Stimulus: TIMEOUT=8; one strobe, then no strobe for 10 cycles.
  - Required: return to IDLE; timeout_err=1, busy=0 at cycle 8; the next A capture clears timeout_err.
- Overrun and ena:
  - Stimulus: a strobe during ISSUE; separately, a strobe pulse entirely within ena=0.
  - Required: overrun_err=1 and operands unchanged; the ena=0 strobe is ignored (state stays IDLE, op_a unchanged).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and pin-map constants for the 4-bit ALU issue path.
// The operand loader and the ALU itself import these definitions.
package alu_pkg;

   localparam int DATA_W_DEF    = 4;
   localparam int OP_W_DEF      = 3;

   // Bit positions of the fields on the 8-bit ui_in pin bus
   localparam int UI_DATA_LSB   = 0;
   localparam int UI_OP_LSB     = 4;
   localparam int UI_STROBE_BIT = 7;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      AND = 3'd2,
      OR  = 3'd3,
      XOR = 3'd4,
      NOT = 3'd5,
      SHL = 3'd6,
      SHR = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GOT_A = 2'd1,
      ISSUE = 2'd2
   } loader_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous pin and flags its rising edge for one cycle.
// The history flop always tracks the synced level, so edges seen while en=0 are dropped.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   input  logic en,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_pulse = en & sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures operand A, then operand B plus opcode, from strobed pins and
// issues the complete operation to the ALU over a valid/ready handshake.
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int OP_W        = OP_W_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [7:0]        ui_in,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [OP_W-1:0]   op_code,
   output logic              op_valid,
   input  logic              op_ready,
   output logic              busy,
   output logic              timeout_err,
   output logic              overrun_err
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   loader_state_e     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              terr_q, terr_d;
   logic              oerr_q, oerr_d;
   logic              valid_q;
   logic              busy_q;
   logic              strobe_evt;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_strobe_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (ui_in[UI_STROBE_BIT]),
      .en         (ena),
      .rise_pulse (strobe_evt)
   );

   // The handshake in ISSUE is deliberately not gated by ena so a ready ALU can drain us
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      terr_d  = terr_q;
      oerr_d  = oerr_q;
      unique case (state_q)
         IDLE: begin
            if (strobe_evt) begin
               a_d     = ui_in[UI_DATA_LSB +: DATA_W];
               terr_d  = 1'b0;
               oerr_d  = 1'b0;
               cnt_d   = '0;
               state_d = GOT_A;
            end
         end
         GOT_A: begin
            if (ena) begin
               if (strobe_evt) begin
                  b_d     = ui_in[UI_DATA_LSB +: DATA_W];
                  op_d    = ui_in[UI_OP_LSB +: OP_W];
                  state_d = ISSUE;
               end else if (cnt_q == CNT_LAST) begin
                  terr_d  = 1'b1;
                  state_d = IDLE;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ISSUE: begin
            if (strobe_evt) begin
               oerr_d = 1'b1;
            end
            if (op_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         terr_q  <= 1'b0;
         oerr_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         terr_q  <= terr_d;
         oerr_q  <= oerr_d;
         valid_q <= (state_d == ISSUE);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign op_a        = a_q;
   assign op_b        = b_q;
   assign op_code     = op_q;
   assign op_valid    = valid_q;
   assign busy        = busy_q;
   assign timeout_err = terr_q;
   assign overrun_err = oerr_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: directed scenarios plus a
// randomized run against a pin-delay-line reference model.
module tb_alu_operand_loader;

   localparam int TO = 8;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic       ena      = 1'b0;
   logic       op_ready = 1'b0;
   logic [7:0] ui_in    = 8'h00;
   logic [3:0] op_a, op_b;
   logic [2:0] op_code;
   logic       op_valid, busy, timeout_err, overrun_err;

   int tests = 0;
   int fails = 0;

   // Reference model: strobe pin samples from the last three edges plus an abstract mode
   logic       s1, s2, s3;
   int         m_mode;
   int         m_cnt;
   logic [3:0] m_a, m_b;
   logic [2:0] m_op;
   logic       m_terr, m_oerr;

   always #5 clk = ~clk;

   alu_operand_loader #(
      .DATA_W      (4),
      .OP_W        (3),
      .SYNC_STAGES (2),
      .TIMEOUT     (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .ui_in       (ui_in),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_code     (op_code),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .busy        (busy),
      .timeout_err (timeout_err),
      .overrun_err (overrun_err)
   );

   task automatic model_reset();
      s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
      m_mode = 0; m_cnt = 0;
      m_a = 4'h0; m_b = 4'h0; m_op = 3'd0;
      m_terr = 1'b0; m_oerr = 1'b0;
   endtask

   task automatic model_step();
      logic ev;
      ev = s2 && !s3 && ena;
      case (m_mode)
         0: if (ev) begin
               m_a = ui_in[3:0]; m_terr = 1'b0; m_oerr = 1'b0; m_cnt = 0; m_mode = 1;
            end
         1: if (ena) begin
               if (ev) begin
                  m_b = ui_in[3:0]; m_op = ui_in[6:4]; m_mode = 2;
               end else if (m_cnt == TO - 1) begin
                  m_mode = 0; m_terr = 1'b1;
               end else begin
                  m_cnt++;
               end
            end
         default: begin
            if (ev) m_oerr = 1'b1;
            if (op_ready) m_mode = 0;
         end
      endcase
      s3 = s2; s2 = s1; s1 = ui_in[7];
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Raises the strobe with the given fields and returns just after the capture edge, strobe low
   task automatic strobe_pulse(input logic [6:0] d);
      ui_in = {1'b1, d};
      tick(); tick(); tick();
      ui_in = {1'b0, d};
   endtask

   task automatic test_reset();
      model_reset();
      #1 rst_n = 1'b0;
      #2;
      tests++; if (op_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", op_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      tests++; if ({timeout_err, overrun_err} !== 2'b00) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 00", {timeout_err, overrun_err}); end
      tests++; if ({op_a, op_b, op_code} !== 11'h000) begin fails++; $display("[TB] FAIL reset_operands: got %h expected 000", {op_a, op_b, op_code}); end
      tick(); tick();
      rst_n = 1'b1;
      ena   = 1'b1;
   endtask

   task automatic test_basic();
      op_ready = 1'b1;
      idle(3);
      ui_in = 8'h8A;
      tick(); tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_a_early: got busy %b expected 0", busy); end
      tick();
      tests++; if (busy !== 1'b1 || op_a !== 4'hA) begin fails++; $display("[TB] FAIL basic_a_capture: got busy %b a %h expected 1 a", busy, op_a); end
      ui_in = 8'h0A;
      tick();
      ui_in = 8'h93;
      tick(); tick();
      tests++; if (op_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_b_early: got valid %b expected 0", op_valid); end
      tick();
      tests++; if (op_valid !== 1'b1 || {op_a, op_b, op_code} !== {4'hA, 4'h3, 3'd1}) begin
         fails++; $display("[TB] FAIL basic_issue: got valid %b data %h expected 1 %h", op_valid, {op_a, op_b, op_code}, {4'hA, 4'h3, 3'd1});
      end
      ui_in = 8'h13;
      tick();
      tests++; if (op_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_one_cycle: got valid %b busy %b expected 0 0", op_valid, busy); end
      tests++; if ({op_a, op_b, op_code} !== {4'hA, 4'h3, 3'd1}) begin fails++; $display("[TB] FAIL basic_hold_after: got %h expected %h", {op_a, op_b, op_code}, {4'hA, 4'h3, 3'd1}); end
   endtask

   task automatic test_backpressure();
      idle(3);
      op_ready = 1'b0;
      strobe_pulse(7'h05);
      tick();
      strobe_pulse(7'h66);
      for (int k = 0; k < 5; k++) begin
         tests++; if (op_valid !== 1'b1 || {op_a, op_b, op_code} !== {4'h5, 4'h6, 3'd6}) begin
            fails++; $display("[TB] FAIL bp_hold[%0d]: got valid %b data %h expected 1 %h", k, op_valid, {op_a, op_b, op_code}, {4'h5, 4'h6, 3'd6});
         end
         tick();
      end
      op_ready = 1'b1;
      tests++; if (op_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_sixth: got valid %b expected 1", op_valid); end
      tick();
      tests++; if (op_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_idle_after: got valid %b busy %b expected 0 0", op_valid, busy); end
   endtask

   task automatic test_timeout();
      idle(3);
      strobe_pulse(7'h05);
      for (int k = 1; k < TO; k++) begin
         tick();
         tests++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL to_wait[%0d]: got busy %b terr %b expected 1 0", k, busy, timeout_err); end
      end
      tick();
      tests++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin fails++; $display("[TB] FAIL to_expire: got busy %b terr %b expected 0 1", busy, timeout_err); end
      tests++; if (op_a !== 4'h5 || op_valid !== 1'b0) begin fails++; $display("[TB] FAIL to_opa: got a %h valid %b expected 5 0", op_a, op_valid); end
      tick(); tick();
      tests++; if (timeout_err !== 1'b1) begin fails++; $display("[TB] FAIL to_sticky: got %b expected 1", timeout_err); end
      strobe_pulse(7'h06);
      tests++; if (timeout_err !== 1'b0 || op_a !== 4'h6 || busy !== 1'b1) begin fails++; $display("[TB] FAIL to_clear: got terr %b a %h busy %b expected 0 6 1", timeout_err, op_a, busy); end
      tick();
      strobe_pulse(7'h21);
      tick();
   endtask

   task automatic test_overrun();
      idle(3);
      op_ready = 1'b0;
      strobe_pulse(7'h0C);
      tick();
      strobe_pulse(7'h4D);
      tests++; if (op_valid !== 1'b1 || overrun_err !== 1'b0) begin fails++; $display("[TB] FAIL ovr_pre: got valid %b oerr %b expected 1 0", op_valid, overrun_err); end
      tick();
      strobe_pulse(7'h71);
      tests++; if (overrun_err !== 1'b1 || op_valid !== 1'b1) begin fails++; $display("[TB] FAIL ovr_set: got oerr %b valid %b expected 1 1", overrun_err, op_valid); end
      tests++; if ({op_a, op_b, op_code} !== {4'hC, 4'hD, 3'd4}) begin fails++; $display("[TB] FAIL ovr_data: got %h expected %h", {op_a, op_b, op_code}, {4'hC, 4'hD, 3'd4}); end
      op_ready = 1'b1;
      tick();
      tests++; if (op_valid !== 1'b0 || overrun_err !== 1'b1) begin fails++; $display("[TB] FAIL ovr_after: got valid %b oerr %b expected 0 1", op_valid, overrun_err); end
      idle(3);
      strobe_pulse(7'h02);
      tests++; if (overrun_err !== 1'b0 || op_a !== 4'h2) begin fails++; $display("[TB] FAIL ovr_clear: got oerr %b a %h expected 0 2", overrun_err, op_a); end
      tick();
      strobe_pulse(7'h03);
      tick();
   endtask

   task automatic test_ena();
      op_ready = 1'b1;
      idle(3);
      strobe_pulse(7'h0B);
      tick();
      strobe_pulse(7'h1B);
      tick();
      idle(2);
      ena   = 1'b0;
      ui_in = 8'h89;
      idle(4);
      ui_in = 8'h09;
      idle(3);
      ena = 1'b1;
      idle(4);
      tests++; if (busy !== 1'b0 || op_valid !== 1'b0) begin fails++; $display("[TB] FAIL ena_ignored: got busy %b valid %b expected 0 0", busy, op_valid); end
      tests++; if (op_a !== 4'hB) begin fails++; $display("[TB] FAIL ena_opa: got %h expected b", op_a); end
   endtask

   task automatic test_reset_mid();
      idle(3);
      op_ready = 1'b0;
      strobe_pulse(7'h0E);
      tick();
      strobe_pulse(7'h5F);
      tick();
      strobe_pulse(7'h11);
      tests++; if (op_valid !== 1'b1 || overrun_err !== 1'b1) begin fails++; $display("[TB] FAIL rmid_pre: got valid %b oerr %b expected 1 1", op_valid, overrun_err); end
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      tests++; if ({op_valid, busy, timeout_err, overrun_err} !== 4'b0000) begin fails++; $display("[TB] FAIL rmid_async: got %b expected 0000", {op_valid, busy, timeout_err, overrun_err}); end
      tests++; if (op_a !== 4'h0) begin fails++; $display("[TB] FAIL rmid_opa: got %h expected 0", op_a); end
      tick();
      rst_n    = 1'b1;
      op_ready = 1'b1;
      idle(2);
      strobe_pulse(7'h04);
      tests++; if (busy !== 1'b1 || op_a !== 4'h4 || op_valid !== 1'b0) begin fails++; $display("[TB] FAIL rmid_recapture: got busy %b a %h valid %b expected 1 4 0", busy, op_a, op_valid); end
      tick();
      strobe_pulse(7'h27);
      tick();
   endtask

   task automatic test_random();
      int         hold;
      logic       strobe;
      logic [6:0] d;
      logic [17:0] exp_v, act_v;
      hold = 0; strobe = 1'b0; d = 7'h00;
      for (int i = 0; i < 800; i++) begin
         ena      = ($urandom_range(0, 9) != 0);
         op_ready = ($urandom_range(0, 2) == 0);
         if (hold == 0) begin
            if (strobe) begin
               strobe = 1'b0;
               hold   = $urandom_range(0, 12);
            end else begin
               strobe = 1'b1;
               d      = 7'($urandom);
               hold   = $urandom_range(0, 5);
            end
         end else begin
            hold--;
         end
         ui_in = {strobe, d};
         tick();
         exp_v = {m_mode == 2, m_mode != 0, m_terr, m_oerr, m_a, m_b, m_op};
         act_v = {op_valid, busy, timeout_err, overrun_err, op_a, op_b, op_code};
         tests++; if (act_v !== exp_v) begin fails++; $display("[TB] FAIL random[%0d]: got %h expected %h", i, act_v, exp_v); end
      end
      ena   = 1'b1;
      ui_in = 8'h00;
      idle(4);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_timeout();
      test_overrun();
      test_ena();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
